// File: rtl/usb_pkg.sv
// Shared USB transmit-side types and constants.
package usb_pkg;

  // Packet request encoding shared with the transmitter.
  typedef enum logic [1:0] {
    PKT_NONE  = 2'b00,
    PKT_DATA0 = 2'b01,
    PKT_ACK   = 2'b10,
    PKT_NAK   = 2'b11
  } tx_packet_t;

  // Largest payload the buffer can hold; sizes are 7 bits wide.
  localparam int USB_MAX_PAYLOAD = 64;

  // Packet launcher states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_buf_state_t;

endpackage : usb_pkg

// File: rtl/usb_tx_fifo.sv
// Show-ahead byte FIFO with occupancy count and sticky overflow/underflow flags.
module usb_tx_fifo
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_MAX_PAYLOAD
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       overflow_o,
  output logic       underflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          empty_s, full_s;
  logic          push_ok_s, pop_ok_s;

  assign empty_s = (count_q == (AW+1)'(0));
  assign full_s  = (count_q == (AW+1)'(DEPTH));

  // Decide which requests are honoured and compute the next pointer/count/flag values.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    pop_ok_s    = pop_i && !empty_s;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    push_ok_s   = push_i && (!full_s || pop_ok_s);
    if (clear_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (push_ok_s && !pop_ok_s) begin
        count_d = count_q + (AW+1)'(1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_d = count_q - (AW+1)'(1);
      end else begin
        count_d = count_q;
      end
      if (push_i && !push_ok_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (pop_i && empty_s) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_q;
      end
    end
  end

  // Pointer, count and error flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Payload storage; contents survive reset and clear, only the pointers move.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !clear_i && !rst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o      = empty_s ? 8'h00 : mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign empty_o     = empty_s;
  assign full_o      = full_s;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule : usb_tx_fifo

// File: rtl/usb_tx_buffer_ctrl.sv
// Transmit buffer and packet launcher feeding usb_tx: stores payload, latches
// packet type and size on launch, and holds the request until tx_done.
module usb_tx_buffer_ctrl
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_MAX_PAYLOAD
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       store_tx_data_i,
  input  logic [7:0] tx_data_i,
  input  logic       send_packet_i,
  input  logic [1:0] packet_type_i,
  input  logic       clear_i,
  input  logic       get_tx_packet_i,
  input  logic       tx_done_i,
  output logic [1:0] tx_packet_o,
  output logic [6:0] tx_packet_data_size_o,
  output logic [7:0] tx_packet_data_o,
  output logic [6:0] buffer_occupancy_o,
  output logic       buffer_empty_o,
  output logic       buffer_full_o,
  output logic       tx_busy_o,
  output logic       overflow_err_o,
  output logic       underflow_err_o,
  output logic       cmd_err_o
);

  tx_buf_state_t state_q, state_d;
  tx_packet_t    type_q, type_d;
  logic [6:0]    size_q, size_d;
  logic          cmd_err_q, cmd_err_d;
  logic          fifo_clear_s;
  logic          launch_s;
  logic [6:0]    occupancy_s;

  // Type 00 is a no-op request and never launches or errors.
  assign launch_s = send_packet_i && (packet_type_i != 2'b00);

  usb_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (fifo_clear_s),
    .push_i      (store_tx_data_i),
    .data_i      (tx_data_i),
    .pop_i       (get_tx_packet_i),
    .head_o      (tx_packet_data_o),
    .count_o     (occupancy_s),
    .empty_o     (buffer_empty_o),
    .full_o      (buffer_full_o),
    .overflow_o  (overflow_err_o),
    .underflow_o (underflow_err_o)
  );

  // Next-state logic: launch, completion, command checking and clear gating.
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    size_d       = size_q;
    cmd_err_d    = cmd_err_q;
    fifo_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          fifo_clear_s = 1'b1;
          cmd_err_d    = 1'b0;
        end else begin
          fifo_clear_s = 1'b0;
        end
        if (launch_s) begin
          state_d = ST_ACTIVE;
          type_d  = tx_packet_t'(packet_type_i);
          // Size reflects the registered count, i.e. before this cycle's push/pop.
          if (packet_type_i == 2'b01) begin
            size_d = occupancy_s;
          end else begin
            size_d = 7'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (launch_s || clear_i) begin
          cmd_err_d = 1'b1;
        end else begin
          cmd_err_d = cmd_err_q;
        end
        if (tx_done_i) begin
          state_d = ST_IDLE;
          type_d  = PKT_NONE;
          size_d  = 7'd0;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        type_d  = PKT_NONE;
        size_d  = 7'd0;
      end
    endcase
  end

  // Launcher state, latched packet fields and command error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      type_q    <= PKT_NONE;
      size_q    <= 7'd0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      size_q    <= size_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign tx_packet_o           = type_q;
  assign tx_packet_data_size_o = size_q;
  assign buffer_occupancy_o    = occupancy_s;
  assign tx_busy_o             = (state_q == ST_ACTIVE);
  assign cmd_err_o             = cmd_err_q;

endmodule : usb_tx_buffer_ctrl

// File: tb/tb_usb_tx_buffer_ctrl.sv
// Directed vector bench for usb_tx_buffer_ctrl.
module tb_usb_tx_buffer_ctrl;

  logic       clk;
  logic       rst;
  logic       store;
  logic [7:0] data;
  logic       send;
  logic [1:0] ptype;
  logic       clr;
  logic       get;
  logic       done;
  logic [1:0] tx_packet;
  logic [6:0] size;
  logic [7:0] head;
  logic [6:0] occ;
  logic       empty, full, busy, ovf, unf, cmd;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        rst;
    logic        store;
    logic [7:0]  data;
    logic        send;
    logic [1:0]  ptype;
    logic        clr;
    logic        get;
    logic        done;
    logic [29:0] exp;
  } vec_t;

  vec_t tbl [23];

  usb_tx_buffer_ctrl #(.DEPTH(64)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .store_tx_data_i       (store),
    .tx_data_i             (data),
    .send_packet_i         (send),
    .packet_type_i         (ptype),
    .clear_i               (clr),
    .get_tx_packet_i       (get),
    .tx_done_i             (done),
    .tx_packet_o           (tx_packet),
    .tx_packet_data_size_o (size),
    .tx_packet_data_o      (head),
    .buffer_occupancy_o    (occ),
    .buffer_empty_o        (empty),
    .buffer_full_o         (full),
    .tx_busy_o             (busy),
    .overflow_err_o        (ovf),
    .underflow_err_o       (unf),
    .cmd_err_o             (cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] pk(input logic [1:0] p, input logic [6:0] s,
                                     input logic [7:0] h, input logic [6:0] o,
                                     input logic e, input logic f, input logic b,
                                     input logic ov, input logic un, input logic c);
    return {p, s, h, o, e, f, b, ov, un, c};
  endfunction

  function automatic logic [29:0] obs();
    return {tx_packet, size, head, occ, empty, full, busy, ovf, unf, cmd};
  endfunction

  function automatic vec_t mk(input logic r, input logic st, input logic [7:0] d,
                              input logic sp, input logic [1:0] pt, input logic cl,
                              input logic g, input logic dn, input logic [29:0] e);
    vec_t v;
    v.rst = r; v.store = st; v.data = d; v.send = sp; v.ptype = pt;
    v.clr = cl; v.get = g; v.done = dn; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic [7:0] d,
                      input logic sp, input logic [1:0] pt, input logic cl,
                      input logic g, input logic dn);
    @(negedge clk);
    rst = r; store = st; data = d; send = sp; ptype = pt; clr = cl; get = g; done = dn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; store = 1'b0; data = 8'h00; send = 1'b0; ptype = 2'b00;
    clr = 1'b0; get = 1'b0; done = 1'b0;

    //               rst   st    data   snd   type   clr   get   done  expected {pkt,size,head,occ,emp,full,busy,ovf,unf,cmd}
    tbl[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[1]  = mk(1'b0, 1'b1, 8'hA5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'hA5, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[2]  = mk(1'b0, 1'b1, 8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'hA5, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[3]  = mk(1'b0, 1'b1, 8'hFF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'hA5, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[4]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, pk(2'd1, 7'd3, 8'hA5, 7'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, pk(2'd1, 7'd3, 8'h3C, 7'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, pk(2'd1, 7'd3, 8'hFF, 7'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, pk(2'd1, 7'd3, 8'h00, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, pk(2'd0, 7'd0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[9]  = mk(1'b0, 1'b1, 8'h11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h11, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[10] = mk(1'b0, 1'b1, 8'h22, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h11, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[11] = mk(1'b0, 1'b1, 8'h33, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h11, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[12] = mk(1'b0, 1'b1, 8'h44, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h11, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[13] = mk(1'b0, 1'b1, 8'h55, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h11, 7'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, pk(2'd2, 7'd0, 8'h11, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl[15] = mk(1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, pk(2'd2, 7'd0, 8'h11, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl[16] = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, pk(2'd2, 7'd0, 8'h11, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl[17] = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, pk(2'd0, 7'd0, 8'h11, 7'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl[18] = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl[19] = mk(1'b0, 1'b1, 8'h77, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, pk(2'd0, 7'd0, 8'h77, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl[20] = mk(1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h77, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl[21] = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, pk(2'd0, 7'd0, 8'h77, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl[22] = mk(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, pk(2'd0, 7'd0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].store, tbl[i].data, tbl[i].send, tbl[i].ptype,
           tbl[i].clr, tbl[i].get, tbl[i].done);
      chk($sformatf("vec%0d", i), {2'b00, obs()}, {2'b00, tbl[i].exp});
    end

    // Fill to the 64-byte boundary with 0x00..0x3F.
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_occ", 32'(occ), 32'd64);
    chk("full_head", 32'(head), 32'h00);

    // 65th push is dropped.
    step(1'b0, 1'b1, 8'hEE, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_occ", 32'(occ), 32'd64);

    // Push and pop together while full.
    step(1'b0, 1'b1, 8'h40, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("pp_occ", 32'(occ), 32'd64);
    chk("pp_head", 32'(head), 32'h01);

    // Drain across the pointer wrap.
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("drain%0d", i), 32'(head), (i < 63) ? 32'(i + 1) : 32'h40);
      step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_head", 32'(head), 32'h00);

    // Reset in the middle of a DATA0 packet with 10 bytes buffered.
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    end
    chk("rm_occ", 32'(occ), 32'd10);
    step(1'b0, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("rm_launch", {2'b00, obs()},
        {2'b00, pk(2'd1, 7'd10, 8'h80, 7'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)});
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("rm_reset", {2'b00, obs()},
        {2'b00, pk(2'd0, 7'd0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("rm_done", {2'b00, obs()},
        {2'b00, pk(2'd0, 7'd0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_usb_tx_buffer_ctrl

// File: doc/usb_tx_buffer_ctrl.md
# usb_tx_buffer_ctrl

Transmit-side data buffer and packet launcher that sits directly upstream of the USB transmitter, `usb_tx`. It stores payload bytes written by the host-facing side in a 64-byte FIFO. On command, it launches a DATA0, ACK or NAK packet by driving `tx_packet` and `tx_packet_data_size`, serves bytes on `get_tx_packet`, and holds the request until `tx_done` returns.

## Interface
- `DEPTH`, 64: FIFO depth in bytes. Must be 64, because the size fields are 7 bits.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `store_tx_data` in 1: push `tx_data` into the FIFO this cycle.
- `tx_data` in 8: byte to push.
- `send_packet` in 1: single-cycle launch command.
- `packet_type` in 2: type for `send_packet`. 01 = DATA0, 10 = ACK, 11 = NAK, 00 = ignored.
- `clear` in 1: flush the FIFO.
- `get_tx_packet` in 1: from `usb_tx`; pop the head byte.
- `tx_done` in 1: from `usb_tx`; single-cycle end-of-packet strobe.
- `tx_packet` out 2: packet request to `usb_tx`. Same encoding as `packet_type`; 00 = idle.
- `tx_packet_data_size` out 7: payload byte count for the active packet.
- `tx_packet_data` out 8: FIFO head byte.
- `buffer_occupancy` out 7: bytes stored, 0..64.
- `buffer_empty` out 1, `buffer_full` out 1: FIFO status.
- `tx_busy` out 1: a packet is outstanding.
- `overflow_err` out 1, `underflow_err` out 1, `cmd_err` out 1: sticky error flags. Cleared only by `rst` or `clear`.

## Operation
- **FSM states:** IDLE, ACTIVE.
- **IDLE → ACTIVE:** taken on `send_packet` with `packet_type` ≠ 00.
  - Latch the type.
  - Latch the size: `buffer_occupancy` for DATA0, sampled before any same-cycle push or pop; 0 for ACK/NAK.
- **ACTIVE:**
  - `tx_packet` holds the latched type and `tx_busy` is 1.
  - On `tx_done`: go to IDLE, `tx_packet` becomes 00, `tx_packet_data_size` becomes 0.
- **`send_packet` in ACTIVE:** ignored, sets `cmd_err`.
- **`send_packet` with type 00:** ignored, no error.
- **FIFO organisation:**
  - Circular buffer with 6-bit read and write pointers that wrap modulo 64.
  - A separate 7-bit count drives `buffer_occupancy`.
  - Show-ahead read: `tx_packet_data` equals the memory at the read pointer when not empty, and 0x00 when empty.
- **Push:**
  - Accepted if not full, or if full with a valid pop in the same cycle.
  - Otherwise dropped and `overflow_err` is set.
- **Pop:**
  - Accepted if not empty.
  - A pop when empty is ignored and sets `underflow_err`; a same-cycle push is still accepted.
- **Simultaneous valid push and pop:** both pointers advance and the count is unchanged.
- **Pushes during ACTIVE:** allowed. They accumulate for the next packet and do not change the latched size.
- **`clear`:**
  - Honoured in IDLE only: zero the pointers, count and error flags.
  - In ACTIVE it is ignored and sets `cmd_err`.
  - `clear` beats push and pop in the same cycle.
- **`tx_done` in IDLE:** ignored.
- **`rst`:** overrides everything. FIFO contents are not reset.

## Timing
- **Reset values:**
  - `tx_packet` = 00, `tx_packet_data_size` = 0, `tx_packet_data` = 0x00, `buffer_occupancy` = 0.
  - `buffer_empty` = 1, `buffer_full` = 0, `tx_busy` = 0, all error flags = 0.
- **Launch latency:** `send_packet` in cycle N gives `tx_packet`, the size and `tx_busy` valid in cycle N+1.
- **Pop latency:** with `get_tx_packet` in cycle N, the next byte appears on `tx_packet_data` in cycle N+1. The consumer samples the head in the same cycle it asserts `get_tx_packet`.
- **Push latency:** a push in cycle N updates occupancy and the flags in N+1. If the FIFO was empty, the head is visible in N+1.
- **`tx_done` in ACTIVE:** in cycle N, `tx_packet` = 00 in N+1. A new `send_packet` is accepted from N+1.
- **Status outputs:** all are registered or derived from registers only. There are no combinational paths from inputs to outputs.

## Structure
- **Shared package `usb_pkg`:**
  - Enum `tx_packet_t` with values PKT_NONE = 2'b00, PKT_DATA0 = 2'b01, PKT_ACK = 2'b10, PKT_NAK = 2'b11.
  - Constant `USB_MAX_PAYLOAD` = 64.
  - FSM state enum `tx_buf_state_t`.
- **Sub-module `usb_tx_fifo`:**
  - Contains the memory, pointers, count, empty/full status and the overflow/underflow flags.
  - Its parent `usb_tx_buffer_ctrl` holds the FSM, the latches and `cmd_err`.

## Test plan
- **Basic DATA0 packet:** reset, push 0xA5, 0x3C, 0xFF, then `send_packet` = 01. Required:
  - Next cycle `tx_packet` = 01, size = 3, head = 0xA5.
  - Three pops yield 0xA5, 0x3C, 0xFF and then empty with head 0x00.
  - `tx_done` gives `tx_packet` = 00 and `tx_busy` = 0.
- **Full boundary and wrap:** push 64 bytes 0x00..0x3F. Required:
  - `buffer_full` = 1 and occupancy = 64.
  - A 65th push sets `overflow_err` and occupancy stays 64.
  - A push+pop in the same cycle while full is accepted; after draining 64 pops the data order is 0x01..0x3F then the new byte.
- **Handshake packets:** `send_packet` = 10 with 5 bytes buffered. Required:
  - Size = 0 and the FIFO is untouched (occupancy 5).
  - `send_packet` during ACTIVE sets `cmd_err` and `tx_packet` stays 10.
- **Underflow:** pop when empty, with a push of 0x77 in the same cycle. Required:
  - `underflow_err` = 1.
  - Occupancy = 1 and head = 0x77 next cycle.
- **Clear rules:** `clear` in ACTIVE is ignored and sets `cmd_err`. After `tx_done`, `clear` in IDLE gives occupancy 0, empty 1 and all errors 0.
- **Reset mid-packet:** assert `rst` while ACTIVE with 10 bytes buffered. Required:
  - All outputs take their reset values the next cycle.
  - `tx_done` after reset has no effect.
